// File: rtl/fft_butterfly_pkg.sv
// fft_butterfly_pkg: shared FFT widths, operand type and the round/saturate helper.
package fft_butterfly_pkg;
  localparam int DEF_LAST_WIDTH = 12;
  localparam int DEF_TW_BIT_WIDTH = 8;
  localparam int RND_CONST = 2 ** (DEF_TW_BIT_WIDTH - 2);
  typedef struct packed {
    logic signed [DEF_LAST_WIDTH:0] re;
    logic signed [DEF_LAST_WIDTH:0] im;
  } complex_t;
  function automatic int sat_max(input int lw);
    return (1 <<< lw) - 1;
  endfunction
  function automatic int sat_min(input int lw);
    return -(1 <<< lw);
  endfunction
  // Round half-up back to Q0 operand scale, then clamp to lw+1 signed bits.
  function automatic int round_sat(input int v, input int tw, input int lw, output logic sat);
    int r;
    r = (v + (1 <<< (tw - 2))) >>> (tw - 1);
    sat = (r > sat_max(lw)) || (r < sat_min(lw));
    return r > sat_max(lw) ? sat_max(lw) : r < sat_min(lw) ? sat_min(lw) : r;
  endfunction
endpackage

// File: rtl/fft_butterfly_if.sv
// fft_butterfly_if: operand/result handshake bundle of the butterfly.
interface fft_butterfly_if import fft_butterfly_pkg::*; #(
  parameter int LAST_WIDTH = DEF_LAST_WIDTH,
  parameter int TW_BIT_WIDTH = DEF_TW_BIT_WIDTH
);
  logic in_valid, in_ready, in_last;
  logic signed [LAST_WIDTH:0] re_a, im_a, re_b, im_b;
  logic signed [TW_BIT_WIDTH-1:0] re_w, im_w;
  logic out_valid, out_ready, out_last;
  logic signed [LAST_WIDTH+1:0] re_x, im_x, re_y, im_y;
  logic sat_clr, sat_flag;
  modport master (
    output in_valid, in_last, re_a, im_a, re_b, im_b, re_w, im_w, out_ready, sat_clr,
    input in_ready, out_valid, out_last, re_x, im_x, re_y, im_y, sat_flag
  );
  modport slave (
    input in_valid, in_last, re_a, im_a, re_b, im_b, re_w, im_w, out_ready, sat_clr,
    output in_ready, out_valid, out_last, re_x, im_x, re_y, im_y, sat_flag
  );
endinterface

// File: rtl/fft_butterfly_complex_multiplier.sv
// complex_multiplier: full-precision gated complex product B*W (zero when disabled).
module complex_multiplier import fft_butterfly_pkg::*; #(
  parameter int LAST_WIDTH = DEF_LAST_WIDTH,
  parameter int TW_BIT_WIDTH = DEF_TW_BIT_WIDTH
) (
  input  logic mult_en,
  input  logic signed [LAST_WIDTH:0] re_b,
  input  logic signed [LAST_WIDTH:0] im_b,
  input  logic signed [TW_BIT_WIDTH-1:0] re_w,
  input  logic signed [TW_BIT_WIDTH-1:0] im_w,
  output logic signed [LAST_WIDTH+TW_BIT_WIDTH+1:0] re_mult,
  output logic signed [LAST_WIDTH+TW_BIT_WIDTH+1:0] im_mult
);
  localparam int MW = LAST_WIDTH + TW_BIT_WIDTH + 2;
  logic signed [MW-1:0] br, bi, wr, wi;
  always_comb begin
    br = MW'(re_b);
    bi = MW'(im_b);
    wr = MW'(re_w);
    wi = MW'(im_w);
    re_mult = mult_en ? br * wr - bi * wi : '0;
    im_mult = mult_en ? br * wi + bi * wr : '0;
  end
endmodule

// File: rtl/fft_butterfly.sv
// fft_butterfly: two-stage radix-2 DIT butterfly, X = A + W*B and Y = A - W*B,
// with valid/ready flow control and a sticky saturation flag.
module fft_butterfly import fft_butterfly_pkg::*; #(
  parameter int LAST_WIDTH = DEF_LAST_WIDTH,
  parameter int TW_BIT_WIDTH = DEF_TW_BIT_WIDTH
) (
  input logic clk,
  input logic rst_n,
  fft_butterfly_if.slave bus
);
  localparam int AW = LAST_WIDTH + 1;
  localparam int RW = LAST_WIDTH + 2;
  localparam int MW = LAST_WIDTH + TW_BIT_WIDTH + 2;
  logic stall, adv, ld, mult_en, sat_r, sat_i;
  logic signed [31:0] p_r, p_i;
  logic signed [MW-1:0] re_mult, im_mult;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, sat_flag_q, sat_flag_d;
  logic signed [MW-1:0] s1_re_mult_q, s1_re_mult_d, s1_im_mult_q, s1_im_mult_d;
  logic signed [AW-1:0] s1_re_a_q, s1_re_a_d, s1_im_a_q, s1_im_a_d;
  logic signed [RW-1:0] re_x_q, re_x_d, im_x_q, im_x_d, re_y_q, re_y_d, im_y_q, im_y_d;
  assign stall = out_valid_q && !bus.out_ready;
  assign adv = !stall;
  // S2 data only loads on real results so outputs hold across bubbles.
  assign ld = adv && s1_valid_q;
  assign mult_en = bus.in_valid && adv;
  complex_multiplier #(.LAST_WIDTH(LAST_WIDTH), .TW_BIT_WIDTH(TW_BIT_WIDTH)) u_cmul (
    .mult_en(mult_en),
    .re_b(bus.re_b),
    .im_b(bus.im_b),
    .re_w(bus.re_w),
    .im_w(bus.im_w),
    .re_mult(re_mult),
    .im_mult(im_mult)
  );
  always_comb begin
    p_r = round_sat(int'(s1_re_mult_q), TW_BIT_WIDTH, LAST_WIDTH, sat_r);
    p_i = round_sat(int'(s1_im_mult_q), TW_BIT_WIDTH, LAST_WIDTH, sat_i);
    s1_valid_d = adv ? bus.in_valid : s1_valid_q;
    s1_last_d = adv ? bus.in_valid && bus.in_last : s1_last_q;
    s1_re_mult_d = adv ? re_mult : s1_re_mult_q;
    s1_im_mult_d = adv ? im_mult : s1_im_mult_q;
    s1_re_a_d = adv ? bus.re_a : s1_re_a_q;
    s1_im_a_d = adv ? bus.im_a : s1_im_a_q;
    out_valid_d = adv ? s1_valid_q : out_valid_q;
    out_last_d = adv ? s1_last_q : out_last_q;
    re_x_d = ld ? RW'(int'(s1_re_a_q) + p_r) : re_x_q;
    im_x_d = ld ? RW'(int'(s1_im_a_q) + p_i) : im_x_q;
    re_y_d = ld ? RW'(int'(s1_re_a_q) - p_r) : re_y_q;
    im_y_d = ld ? RW'(int'(s1_im_a_q) - p_i) : im_y_q;
    sat_flag_d = bus.sat_clr ? 1'b0 : (ld && (sat_r || sat_i)) || sat_flag_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_re_mult_q <= '0;
      s1_im_mult_q <= '0;
      s1_re_a_q <= '0;
      s1_im_a_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      re_x_q <= '0;
      im_x_q <= '0;
      re_y_q <= '0;
      im_y_q <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q <= s1_last_d;
      s1_re_mult_q <= s1_re_mult_d;
      s1_im_mult_q <= s1_im_mult_d;
      s1_re_a_q <= s1_re_a_d;
      s1_im_a_q <= s1_im_a_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      re_x_q <= re_x_d;
      im_x_q <= im_x_d;
      re_y_q <= re_y_d;
      im_y_q <= im_y_d;
      sat_flag_q <= sat_flag_d;
    end
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last = out_last_q;
  assign bus.re_x = re_x_q;
  assign bus.im_x = im_x_q;
  assign bus.re_y = re_y_q;
  assign bus.im_y = im_y_q;
  assign bus.sat_flag = sat_flag_q;
endmodule

// File: tb/tb_fft_butterfly.sv
// tb_fft_butterfly: directed vector table plus back-pressure, bubble, sat_clr and reset sequences.
module tb_fft_butterfly;
  import fft_butterfly_pkg::*;
  localparam int AW = DEF_LAST_WIDTH + 1;
  localparam int WW = DEF_TW_BIT_WIDTH;
  typedef struct {
    int ra, ia, rb, ib, rw, iw;
    int rx, ix, ry, iy;
    bit sat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  vec_t v[8];
  int bpat[8] = '{1, 0, 1, 1, 0, 0, 0, 0};
  fft_butterfly_if bus ();
  fft_butterfly dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x, input logic vld, input logic last);
    bus.in_valid = vld;
    bus.in_last = last;
    bus.re_a = AW'(x.ra);
    bus.im_a = AW'(x.ia);
    bus.re_b = AW'(x.rb);
    bus.im_b = AW'(x.ib);
    bus.re_w = WW'(x.rw);
    bus.im_w = WW'(x.iw);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, got, exp_v, last_x;
    logic acc;
    vec_t z;
    //        ra     ia    rb     ib    rw    iw     rx     ix     ry     iy   sat
    v[0] = '{  100,    0,    64,     0,  127,    0,   164,     0,    36,     0, 0};
    v[1] = '{    0,    0,    64,    32,    0, -128,    32,   -64,   -32,    64, 0};
    v[2] = '{    0,    0, -4096, -4096, -128, -128,     0,  4095,     0, -4095, 1};
    v[3] = '{ -200,   50,   100,  -100,   64,   64,  -100,    50,  -300,    50, 0};
    v[4] = '{    0,    0,     1,     0,   64,    0,     1,     0,    -1,     0, 0};
    v[5] = '{   10,  -10,    -1,     0,   64,    0,    10,   -10,    10,   -10, 0};
    v[6] = '{ 4095,-4096,  4095,     0,  127,    0,  8158, -4096,    32, -4096, 0};
    v[7] = '{-4096,    0, -4096,  4095,  127,  127, -8192,    -1,     0,     1, 1};
    z = '{default: 0};
    drive(z, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    bus.sat_clr = 1'b0;
    #3;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset sat_flag", bus.sat_flag, 0);
    chk("reset out_last", bus.out_last, 0);
    chk("reset re_x", bus.re_x, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(v[i], 1'b1, 1'b0);
      #1;
      chk($sformatf("v%0d in_ready", i), bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d early out_valid", i), bus.out_valid, 0);
      tick();
      chk($sformatf("v%0d out_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d re_x", i), bus.re_x, v[i].rx);
      chk($sformatf("v%0d im_x", i), bus.im_x, v[i].ix);
      chk($sformatf("v%0d re_y", i), bus.re_y, v[i].ry);
      chk($sformatf("v%0d im_y", i), bus.im_y, v[i].iy);
      chk($sformatf("v%0d sat_flag", i), bus.sat_flag, 32'(v[i].sat));
      bus.sat_clr = 1'b1;
      tick();
      bus.sat_clr = 1'b0;
      chk($sformatf("v%0d sat_flag cleared", i), bus.sat_flag, 0);
    end
    drive(v[2], 1'b1, 1'b0);
    tick();
    drive(v[0], 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("sticky re_x", bus.re_x, 164);
    chk("sticky sat_flag", bus.sat_flag, 1);
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    drive(v[2], 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    chk("clr_prio out_valid", bus.out_valid, 1);
    chk("clr_prio sat_flag", bus.sat_flag, 0);
    tick();
    chk("clr_prio sat_flag hold", bus.sat_flag, 0);
    idx = 0;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      z = '{default: 0};
      z.ra = 100 + idx;
      drive(z, idx < 8, idx == 7);
      bus.out_ready = !(c >= 3 && c <= 6);
      #1;
      chk($sformatf("bp c%0d in_ready", c), bus.in_ready, 32'(!(c >= 3 && c <= 6)));
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp item%0d re_x", got), bus.re_x, 100 + got);
        chk($sformatf("bp item%0d out_last", got), bus.out_last, 32'(got == 7));
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp result count", got, 8);
    bus.out_ready = 1'b1;
    last_x = -1;
    for (int c = 0; c < 8; c++) begin
      z = '{default: 0};
      z.ra = bpat[c] != 0 ? 10 * (c + 1) : 999;
      drive(z, bpat[c] != 0, 1'b0);
      #1;
      exp_v = c >= 2 ? bpat[c-2] : 0;
      chk($sformatf("bub c%0d out_valid", c), bus.out_valid, exp_v);
      if (exp_v != 0) begin
        chk($sformatf("bub c%0d re_x", c), bus.re_x, 10 * (c - 1));
        last_x = 10 * (c - 1);
      end else if (last_x >= 0) begin
        chk($sformatf("bub c%0d re_x hold", c), bus.re_x, last_x);
      end
      tick();
    end
    drive(v[2], 1'b1, 1'b0);
    tick();
    drive(v[0], 1'b1, 1'b0);
    tick();
    drive(v[3], 1'b1, 1'b0);
    #1;
    chk("rst pre out_valid", bus.out_valid, 1);
    chk("rst pre sat_flag", bus.sat_flag, 1);
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst sat_flag", bus.sat_flag, 0);
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst re_x", bus.re_x, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("post-rst c%0d out_valid", c), bus.out_valid, 0);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fft_butterfly.md
# fft_butterfly

Pipelined radix-2 DIT butterfly for the feature-extractor FFT. Takes operand pair A, B and twiddle W, forms W·B in the existing `complex_multiplier`, rounds and saturates it back to operand width, and emits X = A + W·B and Y = A − W·B. It sits between the FFT operand buffer / twiddle ROM (upstream) and the stage write-back (downstream). Flow control uses a valid/ready handshake on both sides.

## Interface
- `LAST_WIDTH`, 12: operand magnitude bits; operands are LAST_WIDTH+1 bits signed.
- `TW_BIT_WIDTH`, 8: twiddle width, signed Q1.(TW_BIT_WIDTH−1).
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand set valid.
- `in_ready`  out  1  block accepts the operand set this cycle.
- `in_last`  in  1  tag for the last butterfly of a stage; passed through.
- `re_a`, `im_a`, `re_b`, `im_b`  in  LAST_WIDTH+1  signed operands.
- `re_w`, `im_w`  in  TW_BIT_WIDTH  signed twiddle.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_last`  out  1  delayed `in_last`.
- `re_x`, `im_x`, `re_y`, `im_y`  out  LAST_WIDTH+2  signed results (one bit of growth).
- `sat_clr`  in  1  synchronous clear of `sat_flag`.
- `sat_flag`  out  1  sticky: a W·B component saturated since the last clear.

## Operation
- Accept: transfer when `in_valid && in_ready`. `mult_en` of the multiplier = `in_valid && in_ready`. The products are zero otherwise.
- Stage 1 (S1) registers:
  - raw `Re_mult`, `Im_mult` (LAST_WIDTH+TW_BIT_WIDTH+2 bits);
  - A;
  - `in_last`;
  - `s1_valid`.
- Stage 2 (S2), combinational from S1:
  - p_r = (Re_mult + 2^(TW_BIT_WIDTH−2)) >>> (TW_BIT_WIDTH−1), arithmetic shift, round-half-up; same for p_i.
  - Saturate p_r and p_i to LAST_WIDTH+1 bits signed, i.e. [−2^LAST_WIDTH, 2^LAST_WIDTH−1].
  - Sign-extend A and the saturated W·B to LAST_WIDTH+2 bits.
  - X = A + W·B, Y = A − W·B. These cannot overflow.
- S2 registers X, Y, `out_last`, `out_valid`.
- Stall: stall = `out_valid && !out_ready`. While stalled:
  - `in_ready` = 0;
  - S1 and S2 hold their contents;
  - `sat_flag` holds, apart from `sat_clr`.
- When not stalled, both stages advance every cycle. `s1_valid` loads `in_valid` (a bubble propagates as a bubble; bubbles are not compressed).
- `in_ready` = !stall. It is combinational from `out_valid` and `out_ready`; there is no dependence on `in_valid`.
- `sat_flag`:
  - set in the cycle S1 advances into S2 with `s1_valid` = 1 and either component saturating;
  - `sat_clr` takes priority over a simultaneous set.
- Output data is registered. Outputs hold their last value when `out_valid` = 0. Data is meaningful only while `out_valid` = 1.

## Timing
- Latency: 2 cycles from accept to `out_valid` when there is no stall. Throughput is 1 butterfly per cycle.
- Reset (`rst_n` low, asynchronous):
  - `s1_valid`, `out_valid`, `out_last` and `sat_flag` go to 0;
  - all data registers go to 0;
  - therefore `in_ready` = 1.
- Reset asserted mid-operation discards in-flight butterflies. No output is produced for them.
- After `rst_n` deasserts, the first accept is possible in the same cycle.
- Stall release: in the cycle `out_ready` = 1 with `out_valid` = 1, the result transfers, S2 loads S1, and a new input may be accepted.
- `sat_clr` together with a new saturation event leaves `sat_flag` = 0.

## Structure
- Shared FFT package holds:
  - a `complex_t`-style packed struct typedef for operands;
  - localparam `RND_CONST` = 2^(TW_BIT_WIDTH−2);
  - saturation bounds as functions of LAST_WIDTH.
- One sub-module instance: the existing `complex_multiplier`, parameterised with the same LAST_WIDTH and TW_BIT_WIDTH.
- The round/saturate helper is a package function, not a module.

## Test plan
All cases use LAST_WIDTH = 12, TW_BIT_WIDTH = 8.
- Identity twiddle: A = (100, 0), B = (64, 0), W = (127, 0). Required: X = (164, 0), Y = (36, 0), `out_valid` exactly 2 cycles after accept, `sat_flag` = 0.
- −j twiddle with rounding: A = (0, 0), B = (64, 32), W = (0, −128). Required: W·B = (32, −64), X = (32, −64), Y = (−32, 64).
- Saturation: A = (0, 0), B = (−4096, −4096), W = (−128, −128). Required: im of W·B saturates to 4095, X = (0, 4095), Y = (0, −4095), `sat_flag` = 1 from the next cycle. Then `sat_clr` pulse: `sat_flag` = 0.
- Back-pressure: stream 8 butterflies with `out_ready` low for cycles 3–6. Required:
  - `in_ready` is low exactly while `out_valid && !out_ready`;
  - there is no loss or duplication;
  - outputs appear in order;
  - `out_last` is aligned with the 8th result.
- Bubbles: `in_valid` pattern 1,0,1,1,0 with `out_ready` = 1. Required: the same `out_valid` pattern, delayed by 2 cycles.
- Reset mid-stream: assert `rst_n` = 0 with both stages full. Required:
  - `out_valid` = 0 and `sat_flag` = 0 immediately (asynchronous);
  - `in_ready` = 1;
  - no stale output appears after release.
